// File: rtl/divisor_sweep_controller.sv
// divisor_sweep_controller
//
// Turns up / down / restore key levels into a bounded frequency divisor for
// the downstream divider counter.
//
// Optional feature macro: DIVSWEEP_AUTOREPEAT_EN
//   defined   : hold-to-repeat FSM (IDLE / DELAY / REPEAT) with a 16-bit
//               counter is compiled in.
//   undefined : only press edges step; holding a key gives exactly one step.
//               REPEAT_DELAY / REPEAT_RATE are ignored and dbg_state reads IDLE.
//
// Key handling:
//   key_q is the first register stage, key_qq the second. A press is
//   key_q & ~key_qq and a hold is key_q & key_qq. Holding both direction keys
//   blocks stepping. When one of them is released, the key still held is
//   treated as a fresh press. The up press term is
//   up_q & ~dn_q & (~up_qq | dn_qq), and the down term is symmetric.
//
// Handshake: none. All inputs are levels and all outputs are plain registers
// or decodes of registers. changed is high for exactly the cycle in which
// frequency_divisor shows a new value. A restore press always counts as a
// change.
//
// Timing: a key that is high before edge N is captured at edge N.
// frequency_divisor and changed update at edge N+1.

module divisor_sweep_controller #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] MIN_DIV      = 32'd1130,
  parameter logic [WIDTH-1:0] MAX_DIV      = 32'd1140,
  parameter logic [WIDTH-1:0] DEFAULT_DIV  = 32'd1135,
  parameter logic [WIDTH-1:0] STEP         = 32'd1,
  parameter logic             WRAP         = 1'b0,
  parameter logic [15:0]      REPEAT_DELAY = 16'd8,
  parameter logic [15:0]      REPEAT_RATE  = 16'd4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_restore,
  output logic [WIDTH-1:0] frequency_divisor,
  output logic             changed,
  output logic             at_min,
  output logic             at_max,
  output logic [1:0]       dbg_state
);

  // Repeat FSM encoding (also reported on dbg_state)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Direction held by the repeat FSM
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // ---------------------------------------------------------------------------
  // Key synchronisation / edge detection registers
  // ---------------------------------------------------------------------------
  logic r_up_q;
  logic r_up_qq;
  logic r_dn_q;
  logic r_dn_qq;
  logic r_rs_q;
  logic r_rs_qq;

  // Two-stage key registers; cleared on reset so a key held through reset
  // release is seen as a new press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_up_q  <= 1'b0;
      r_up_qq <= 1'b0;
      r_dn_q  <= 1'b0;
      r_dn_qq <= 1'b0;
      r_rs_q  <= 1'b0;
      r_rs_qq <= 1'b0;
    end else begin
      r_up_q  <= key_up;
      r_up_qq <= r_up_q;
      r_dn_q  <= key_down;
      r_dn_qq <= r_dn_q;
      r_rs_q  <= key_restore;
      r_rs_qq <= r_rs_q;
    end
  end

  logic w_rs_press;
  logic w_up_press;
  logic w_dn_press;

  // Restore is a plain rising edge. A direction key counts as pressed on its
  // own rising edge, or when the other key is released while it is still held.
  assign w_rs_press = r_rs_q & ~r_rs_qq;
  assign w_up_press = r_up_q & ~r_dn_q & (~r_up_qq | r_dn_qq);
  assign w_dn_press = r_dn_q & ~r_up_q & (~r_dn_qq | r_up_qq);

  // ---------------------------------------------------------------------------
  // Divisor arithmetic (one extra bit so cur + STEP cannot overflow)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_div;
  logic             r_changed;

  logic [WIDTH:0]   w_up_sum;
  logic [WIDTH:0]   w_dn_floor;
  logic [WIDTH-1:0] w_up_val;
  logic [WIDTH-1:0] w_dn_val;

  // Candidate values for one step up and one step down from the current value
  always_comb begin
    w_up_sum   = {1'b0, r_div} + {1'b0, STEP};
    w_dn_floor = {1'b0, MIN_DIV} + {1'b0, STEP};
    if (w_up_sum > {1'b0, MAX_DIV}) begin
      w_up_val = WRAP ? MIN_DIV : MAX_DIV;
    end else begin
      w_up_val = w_up_sum[WIDTH-1:0];
    end
    if ({1'b0, r_div} < w_dn_floor) begin
      w_dn_val = WRAP ? MAX_DIV : MIN_DIV;
    end else begin
      w_dn_val = r_div - STEP;
    end
  end

  // ---------------------------------------------------------------------------
  // Step request generation
  // ---------------------------------------------------------------------------
  logic w_step_up;
  logic w_step_dn;

`ifdef DIVSWEEP_AUTOREPEAT_EN

  logic [1:0]  r_state;
  logic [15:0] r_cnt;
  logic        r_dir;

  logic [1:0]  w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic        w_dir_nxt;
  logic        w_up_hold;
  logic        w_dn_hold;
  logic        w_hold_same;

  // A key is being held on its own (the other direction key is not held)
  assign w_up_hold   = r_up_q & ~r_dn_q;
  assign w_dn_hold   = r_dn_q & ~r_up_q;
  assign w_hold_same = (r_dir == DIR_DN) ? w_dn_hold : w_up_hold;

  // Repeat FSM next-state: restore wins, a held key advances the counter,
  // anything else falls back to IDLE and may start a new press the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_step_up   = 1'b0;
    w_step_dn   = 1'b0;
    if (w_rs_press) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 16'd0;
    end else if ((r_state != ST_IDLE) && w_hold_same) begin
      if (r_cnt == 16'd0) begin
        w_step_up   = (r_dir == DIR_UP);
        w_step_dn   = (r_dir == DIR_DN);
        w_cnt_nxt   = REPEAT_RATE - 16'd1;
        w_state_nxt = ST_REPEAT;
      end else begin
        w_cnt_nxt = r_cnt - 16'd1;
      end
    end else begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 16'd0;
      if (w_up_press) begin
        w_step_up   = 1'b1;
        w_dir_nxt   = DIR_UP;
        w_cnt_nxt   = REPEAT_DELAY - 16'd1;
        w_state_nxt = ST_DELAY;
      end else if (w_dn_press) begin
        w_step_dn   = 1'b1;
        w_dir_nxt   = DIR_DN;
        w_cnt_nxt   = REPEAT_DELAY - 16'd1;
        w_state_nxt = ST_DELAY;
      end
    end
  end

  // Repeat FSM state, counter and held direction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_dir   <= DIR_UP;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  assign dbg_state = r_state;

`else

  // Without auto-repeat only a press edge steps; restore still takes priority
  assign w_step_up = ~w_rs_press & w_up_press;
  assign w_step_dn = ~w_rs_press & w_dn_press;
  assign dbg_state = ST_IDLE;

`endif

  // ---------------------------------------------------------------------------
  // Divisor register and change pulse
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_div_nxt;
  logic             w_changed_nxt;

  // Select the next divisor; changed only when the value really moves,
  // except restore which always pulses.
  always_comb begin
    w_div_nxt     = r_div;
    w_changed_nxt = 1'b0;
    if (w_rs_press) begin
      w_div_nxt     = DEFAULT_DIV;
      w_changed_nxt = 1'b1;
    end else if (w_step_up) begin
      w_div_nxt     = w_up_val;
      w_changed_nxt = (w_up_val != r_div);
    end else if (w_step_dn) begin
      w_div_nxt     = w_dn_val;
      w_changed_nxt = (w_dn_val != r_div);
    end
  end

  // Registered divisor and change pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div     <= DEFAULT_DIV;
      r_changed <= 1'b0;
    end else begin
      r_div     <= w_div_nxt;
      r_changed <= w_changed_nxt;
    end
  end

  assign frequency_divisor = r_div;
  assign changed           = r_changed;
  assign at_min            = (r_div == MIN_DIV);
  assign at_max            = (r_div == MAX_DIV);

endmodule

// File: tb/tb_divisor_sweep_controller.sv
// Directed bench for divisor_sweep_controller.
// Instance a: default parameters (saturating). Instance b: WRAP=1, default 1140.
// Expectations follow DIVSWEEP_AUTOREPEAT_EN when it is defined.

module tb_divisor_sweep_controller;

`ifdef DIVSWEEP_AUTOREPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  localparam logic [31:0] ST_DELAY_EXP  = (AR != 0) ? 32'd1 : 32'd0;
  localparam logic [31:0] ST_REPEAT_EXP = (AR != 0) ? 32'd2 : 32'd0;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  logic        key_up;
  logic        key_down;
  logic        key_restore;
  logic [31:0] a_div;
  logic        a_chg;
  logic        a_min;
  logic        a_max;
  logic [1:0]  a_st;

  logic        u2;
  logic        d2;
  logic        r2;
  logic [31:0] b_div;
  logic        b_chg;
  logic        b_min;
  logic        b_max;
  logic [1:0]  b_st;

  divisor_sweep_controller dut_a (
    .clk               (clk),
    .reset             (reset),
    .key_up            (key_up),
    .key_down          (key_down),
    .key_restore       (key_restore),
    .frequency_divisor (a_div),
    .changed           (a_chg),
    .at_min            (a_min),
    .at_max            (a_max),
    .dbg_state         (a_st)
  );

  divisor_sweep_controller #(
    .WRAP        (1'b1),
    .DEFAULT_DIV (32'd1140)
  ) dut_b (
    .clk               (clk),
    .reset             (reset),
    .key_up            (u2),
    .key_down          (d2),
    .key_restore       (r2),
    .frequency_divisor (b_div),
    .changed           (b_chg),
    .at_min            (b_min),
    .at_max            (b_max),
    .dbg_state         (b_st)
  );

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Advance n rising edges and settle 1 time unit after the last one
  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restore_a(input string tag);
    key_restore = 1'b1;
    step_n(1);
    key_restore = 1'b0;
    step_n(1);
    check({tag, "_div"}, a_div, 32'd1135);
    check({tag, "_chg"}, {31'd0, a_chg}, 32'd1);
    step_n(1);
  endtask

  task automatic press_up_a();
    key_up = 1'b1;
    step_n(1);
    key_up = 1'b0;
    step_n(2);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset       = 1'b1;
    key_up      = 1'b0;
    key_down    = 1'b0;
    key_restore = 1'b0;
    u2          = 1'b0;
    d2          = 1'b0;
    r2          = 1'b0;
    step_n(3);

    // Reset state
    check("rst_div",   a_div, 32'd1135);
    check("rst_chg",   {31'd0, a_chg}, 32'd0);
    check("rst_min",   {31'd0, a_min}, 32'd0);
    check("rst_max",   {31'd0, a_max}, 32'd0);
    check("rst_state", {30'd0, a_st}, 32'd0);
    check("rst_b_div", b_div, 32'd1140);
    check("rst_b_max", {31'd0, b_max}, 32'd1);

    reset = 1'b0;
    step_n(1);

    // One-cycle up pulse: value moves two edges after the key is raised
    key_up = 1'b1;
    step_n(1);
    key_up = 1'b0;
    check("t1_pre_div", a_div, 32'd1135);
    check("t1_pre_chg", {31'd0, a_chg}, 32'd0);
    step_n(1);
    check("t1_div",   a_div, 32'd1136);
    check("t1_chg",   {31'd0, a_chg}, 32'd1);
    check("t1_min",   {31'd0, a_min}, 32'd0);
    check("t1_max",   {31'd0, a_max}, 32'd0);
    check("t1_state", {30'd0, a_st}, ST_DELAY_EXP);
    step_n(1);
    check("t1_chg_off", {31'd0, a_chg}, 32'd0);
    check("t1_idle",    {30'd0, a_st}, 32'd0);
    restore_a("t1_rs");
    step_n(1);

    // Hold key_down for 40 cycles
    key_down = 1'b1;
    step_n(2);
    check("t2_p1_div", a_div, 32'd1134);
    check("t2_p1_chg", {31'd0, a_chg}, 32'd1);
    step_n(7);
    check("t2_p8_div", a_div, 32'd1134);
    check("t2_p8_chg", {31'd0, a_chg}, 32'd0);
    step_n(1);
    check("t2_p9_div", a_div, (AR != 0) ? 32'd1133 : 32'd1134);
    check("t2_p9_chg", {31'd0, a_chg}, (AR != 0) ? 32'd1 : 32'd0);
    step_n(4);
    check("t2_p13_div",   a_div, (AR != 0) ? 32'd1132 : 32'd1134);
    check("t2_p13_state", {30'd0, a_st}, ST_REPEAT_EXP);
    step_n(4);
    check("t2_p17_div", a_div, (AR != 0) ? 32'd1131 : 32'd1134);
    step_n(4);
    check("t2_p21_div", a_div, (AR != 0) ? 32'd1130 : 32'd1134);
    check("t2_p21_min", {31'd0, a_min}, (AR != 0) ? 32'd1 : 32'd0);
    check("t2_p21_chg", {31'd0, a_chg}, (AR != 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < 19; i++) begin
      step_n(1);
      check("t2_sat_chg", {31'd0, a_chg}, 32'd0);
    end
    check("t2_end_div", a_div, (AR != 0) ? 32'd1130 : 32'd1134);
    key_down = 1'b0;
    step_n(3);
    check("t2_idle", {30'd0, a_st}, 32'd0);
    restore_a("t2_rs");

    // Wrap instance: 1140 -> up -> 1130, then 1130 -> down -> 1140
    u2 = 1'b1;
    step_n(1);
    u2 = 1'b0;
    step_n(1);
    check("t3_up_div", b_div, 32'd1130);
    check("t3_up_chg", {31'd0, b_chg}, 32'd1);
    check("t3_up_min", {31'd0, b_min}, 32'd1);
    check("t3_up_max", {31'd0, b_max}, 32'd0);
    step_n(2);
    d2 = 1'b1;
    step_n(1);
    d2 = 1'b0;
    step_n(1);
    check("t3_dn_div", b_div, 32'd1140);
    check("t3_dn_chg", {31'd0, b_chg}, 32'd1);
    check("t3_dn_max", {31'd0, b_max}, 32'd1);
    step_n(2);

    // Saturation at the top on the non-wrapping instance
    for (int i = 0; i < 5; i++) press_up_a();
    check("sat_div", a_div, 32'd1140);
    check("sat_max", {31'd0, a_max}, 32'd1);
    key_up = 1'b1;
    step_n(1);
    key_up = 1'b0;
    step_n(1);
    check("sat_hold_div", a_div, 32'd1140);
    check("sat_hold_chg", {31'd0, a_chg}, 32'd0);
    step_n(2);
    restore_a("sat_rs");

    // Both keys together, then release down while up stays held
    key_up   = 1'b1;
    key_down = 1'b1;
    step_n(2);
    check("t4_both_div", a_div, 32'd1135);
    check("t4_both_chg", {31'd0, a_chg}, 32'd0);
    step_n(3);
    check("t4_hold_div", a_div, 32'd1135);
    check("t4_hold_chg", {31'd0, a_chg}, 32'd0);
    key_down = 1'b0;
    step_n(1);
    check("t4_rel1_div", a_div, 32'd1135);
    step_n(1);
    check("t4_rel2_div", a_div, 32'd1136);
    check("t4_rel2_chg", {31'd0, a_chg}, 32'd1);
    step_n(7);
    check("t4_rel9_div", a_div, 32'd1136);
    step_n(1);
    check("t4_rep_div", a_div, (AR != 0) ? 32'd1137 : 32'd1136);
    key_up = 1'b0;
    step_n(3);

    // Restore together with up from 1138
    restore_a("t5_pre");
    for (int i = 0; i < 3; i++) press_up_a();
    check("t5_start", a_div, 32'd1138);
    key_restore = 1'b1;
    key_up      = 1'b1;
    step_n(2);
    check("t5_div", a_div, 32'd1135);
    check("t5_chg", {31'd0, a_chg}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      step_n(1);
      check("t5_hold_chg", {31'd0, a_chg}, 32'd0);
    end
    check("t5_end_div", a_div, 32'd1135);
    key_restore = 1'b0;
    key_up      = 1'b0;
    step_n(3);

    // Reset in the middle of DELAY with the key still held
    key_up = 1'b1;
    step_n(2);
    check("t6_p1_div",   a_div, 32'd1136);
    check("t6_p1_state", {30'd0, a_st}, ST_DELAY_EXP);
    step_n(4);
    reset = 1'b1;
    step_n(1);
    check("t6_rst_div",   a_div, 32'd1135);
    check("t6_rst_chg",   {31'd0, a_chg}, 32'd0);
    check("t6_rst_state", {30'd0, a_st}, 32'd0);
    reset = 1'b0;
    step_n(1);
    check("t6_e1_div", a_div, 32'd1135);
    step_n(1);
    check("t6_e2_div", a_div, 32'd1136);
    check("t6_e2_chg", {31'd0, a_chg}, 32'd1);
    step_n(7);
    check("t6_norep_div", a_div, 32'd1136);
    step_n(1);
    check("t6_rep_div", a_div, (AR != 0) ? 32'd1137 : 32'd1136);
    key_up = 1'b0;
    step_n(2);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divisor_sweep_controller.md
# divisor_sweep_controller

Parametrised next-generation frequency-divisor generator: turns up, down and restore key inputs into a bounded divisor for the downstream clock divider / tone generator. Adds configurable width, step size, default value, saturate-or-wrap limit handling and hold-to-repeat on top of the single-step press behaviour. It sits between the board key inputs and the divider counter.

## Interface
- WIDTH, 32: width of the divisor and all arithmetic.
- MIN_DIV, 32'd1130: lowest legal divisor.
- MAX_DIV, 32'd1140: highest legal divisor.
- DEFAULT_DIV, 32'd1135: value after reset or restore; must lie in [MIN_DIV, MAX_DIV].
- STEP, 32'd1: increment per step; must be ≥1 and ≤ MAX_DIV-MIN_DIV.
- WRAP, 1'b0: 0 = saturate at limits, 1 = wrap to the opposite limit.
- REPEAT_DELAY, 16'd8: clk cycles a key must be held after its first step before auto-repeat starts.
- REPEAT_RATE, 16'd4: clk cycles between auto-repeat steps.
- clk, in, 1: system clock; all logic is on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- key_up, in, 1: active-high level; increase divisor.
- key_down, in, 1: active-high level; decrease divisor.
- key_restore, in, 1: active-high level; load DEFAULT_DIV.
- frequency_divisor, out, WIDTH: current divisor, registered.
- changed, out, 1: one-cycle pulse, high in the cycle frequency_divisor takes a new value.
- at_min, out, 1: frequency_divisor == MIN_DIV.
- at_max, out, 1: frequency_divisor == MAX_DIV.

## Operation
- Each key is registered into key_q, and key_q into key_qq. A press is key_q & ~key_qq; a hold is key_q & key_qq.
- Priority per cycle: reset > restore press > up/down.
- Restore press: load DEFAULT_DIV. changed pulses even when the value is already DEFAULT_DIV. Repeat FSM → IDLE.
- up and down held together (key_q both high): no step. Repeat FSM → IDLE.
- Step up: next = cur + STEP, computed in WIDTH+1 bits. If next > MAX_DIV: saturate to MAX_DIV (WRAP=0) or load MIN_DIV (WRAP=1).
- Step down: if cur < MIN_DIV + STEP: saturate to MIN_DIV (WRAP=0) or load MAX_DIV (WRAP=1).
- changed pulses only when the value actually differs, except on restore. A saturated step at a limit gives no pulse.
- Repeat FSM with states IDLE, DELAY, REPEAT and a 16-bit counter:
  - IDLE: a press of exactly one direction key steps once, loads the counter with REPEAT_DELAY-1, and goes to DELAY.
  - DELAY: the counter decrements while the same key is held. At 0 the block steps, loads REPEAT_RATE-1 and goes to REPEAT.
  - REPEAT: at 0 the block steps and reloads REPEAT_RATE-1.
  - Release, a direction change, or both keys held returns the FSM to IDLE without a step. A new press in the same cycle is handled as an IDLE press.
- Restore has no repeat. Holding restore gives one load only.

## Timing
- Reset values:
  - frequency_divisor = DEFAULT_DIV
  - changed = 0
  - at_min and at_max decoded from DEFAULT_DIV
  - key_q, key_qq = 0
  - FSM = IDLE, counter = 0
- A key held through reset release is treated as a new press, so it steps 2 edges after reset deasserts.
- Press latency: input high before edge N sets key_q at edge N. frequency_divisor and changed update at edge N+1.
- Repeat timing: the first repeat step comes REPEAT_DELAY cycles after the press step. Later steps are every REPEAT_RATE cycles.
- Reset asserted mid-repeat aborts the FSM on the same edge. No step is taken in that cycle.
- at_min and at_max are combinational from the frequency_divisor register.

## Configuration
- DIVSWEEP_AUTOREPEAT_EN defined: the repeat FSM and counter are compiled in, as described above.
- DIVSWEEP_AUTOREPEAT_EN undefined: FSM and counter are removed. Only press edges step, and holding a key gives exactly one step. REPEAT_DELAY and REPEAT_RATE are ignored. All other behaviour and latency are unchanged.

## Test plan
Defaults used: WIDTH=32, MIN=1130, MAX=1140, DEFAULT=1135, STEP=1, DELAY=8, RATE=4.
- Reset, then a 1-cycle key_up pulse: divisor 1135 → 1136 two edges after assertion; changed high for exactly 1 cycle; at_min = at_max = 0.
- Hold key_down for 40 cycles with macro defined: 1134 at press+1, 1133 at +9, then 1132/1131/1130 every 4 cycles; saturates at 1130 with at_min=1 and no further changed pulses. Same stimulus with macro undefined: single step to 1134.
- WRAP=1, divisor at 1140, key_up press: divisor 1130, changed=1. Repeat with key_down at 1130: divisor 1140.
- key_up and key_down asserted in the same cycle: divisor unchanged, no changed pulse. Then release key_down while holding key_up: key_up restarts as a fresh press, stepping at key_down release + 2 edges and restarting the repeat timing from there.
- Divisor at 1138, key_restore press together with key_up: divisor 1135, changed pulses once, and holding both keys for 20 cycles causes no further change.
- Reset asserted at cycle 5 of the DELAY state: divisor reads 1135 after that edge and no repeat step follows. Key still held at reset release: a step to 1136 two edges later.
